// File: rtl/reg_scoreboard_if.sv
// rtl/reg_scoreboard_if.sv - decode/writeback handshake bundle between the Tinker pipeline and its register scoreboard
interface reg_scoreboard_if #(
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = 5
);
    logic                dec_valid;
    logic [REG_AW-1:0]   dec_rs;
    logic [REG_AW-1:0]   dec_rt;
    logic [REG_AW-1:0]   dec_rd;
    logic                dec_uses_rs;
    logic                dec_uses_rt;
    logic                dec_writes_rd;
    logic                wb_valid;
    logic [REG_AW-1:0]   wb_rd;
    logic                stall_en;
    logic                issue;
    logic [NUM_REGS-1:0] busy_mask;
    logic                deadlock;

    modport master (
        output dec_valid, dec_rs, dec_rt, dec_rd,
        output dec_uses_rs, dec_uses_rt, dec_writes_rd,
        output wb_valid, wb_rd,
        input  stall_en, issue, busy_mask, deadlock
    );

    modport slave (
        input  dec_valid, dec_rs, dec_rt, dec_rd,
        input  dec_uses_rs, dec_uses_rt, dec_writes_rd,
        input  wb_valid, wb_rd,
        output stall_en, issue, busy_mask, deadlock
    );
endinterface

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - pending-write scoreboard producing the pc stall_en and a sticky deadlock flag
module reg_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = 5,
    parameter int R0_ZERO  = 0,
    parameter int TIMEOUT  = 255
) (
    input logic clk,
    input logic rst_n,
    reg_scoreboard_if.slave sb
);
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [7:0]          stall_cnt;
    logic [7:0]          cnt_inc;
    logic                deadlock;
    logic                hazard;
    logic                issue;

    // Out-of-range indices match no entry, so they never hit, set or clear.
    function automatic logic reg_busy(input logic [REG_AW-1:0] idx,
                                      input logic [NUM_REGS-1:0] mask);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == REG_AW'(i) && !(R0_ZERO != 0 && i == 0)) r = mask[i];
        end
        return r;
    endfunction

    always_comb begin
        hazard = sb.dec_valid & ((sb.dec_uses_rs   & reg_busy(sb.dec_rs, busy)) |
                                 (sb.dec_uses_rt   & reg_busy(sb.dec_rt, busy)) |
                                 (sb.dec_writes_rd & reg_busy(sb.dec_rd, busy)));
        issue  = sb.dec_valid & ~hazard;
    end

    // Set wins over clear on the same index: the issuing writer is younger.
    always_comb begin
        busy_nxt = busy;
        for (int i = 0; i < NUM_REGS; i++) begin
            busy_nxt[i] = (issue & sb.dec_writes_rd & (sb.dec_rd == REG_AW'(i))) |
                          (busy[i] & ~(sb.wb_valid & (sb.wb_rd == REG_AW'(i))));
        end
        if (R0_ZERO != 0) busy_nxt[0] = 1'b0;
    end

    always_comb begin
        cnt_inc = (stall_cnt == 8'hFF) ? stall_cnt : stall_cnt + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= '0;
            stall_cnt <= 8'd0;
            deadlock  <= 1'b0;
        end else begin
            busy <= busy_nxt;
            if (hazard) begin
                stall_cnt <= cnt_inc;
                if (cnt_inc >= 8'(TIMEOUT)) deadlock <= 1'b1;
            end else begin
                stall_cnt <= 8'd0;
            end
        end
    end

    assign sb.stall_en  = ~hazard;
    assign sb.issue     = issue;
    assign sb.busy_mask = busy;
    assign sb.deadlock  = deadlock;
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - vector table with expected-result queue plus stall, deadlock and reset sequences
module tb_reg_scoreboard;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    reg_scoreboard_if #(.NUM_REGS(32), .REG_AW(5)) sb();

    reg_scoreboard #(.NUM_REGS(32), .REG_AW(5), .R0_ZERO(0), .TIMEOUT(255)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sb)
    );

    typedef struct {
        logic        valid;
        logic [4:0]  rs, rt, rd;
        logic        urs, urt, wrd;
        logic        wbv;
        logic [4:0]  wbrd;
        logic        exp_stall;
        logic        exp_issue;
        logic [31:0] exp_mask;
    } vec_t;

    typedef struct {
        logic        stall;
        logic        issue;
        logic [31:0] mask;
    } exp_t;

    vec_t vecs[$];
    exp_t expq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input int rs, input int rt, input int rd,
                                input logic urs, input logic urt, input logic wrd,
                                input logic wbv, input int wbrd,
                                input logic st, input logic is, input logic [31:0] m);
        vec_t r;
        r.valid = v; r.rs = 5'(rs); r.rt = 5'(rt); r.rd = 5'(rd);
        r.urs = urs; r.urt = urt; r.wrd = wrd; r.wbv = wbv; r.wbrd = 5'(wbrd);
        r.exp_stall = st; r.exp_issue = is; r.exp_mask = m;
        return r;
    endfunction

    task automatic drive(input logic v, input int rs, input int rt, input int rd,
                         input logic urs, input logic urt, input logic wrd,
                         input logic wbv, input int wbrd);
        sb.dec_valid = v; sb.dec_rs = 5'(rs); sb.dec_rt = 5'(rt); sb.dec_rd = 5'(rd);
        sb.dec_uses_rs = urs; sb.dec_uses_rt = urt; sb.dec_writes_rd = wrd;
        sb.wb_valid = wbv; sb.wb_rd = 5'(wbrd);
    endtask

    task automatic apply(input int idx, input vec_t v);
        exp_t e;
        drive(v.valid, int'(v.rs), int'(v.rt), int'(v.rd), v.urs, v.urt, v.wrd, v.wbv, int'(v.wbrd));
        e.stall = v.exp_stall; e.issue = v.exp_issue; e.mask = v.exp_mask;
        expq.push_back(e);
        @(negedge clk);
        e = expq.pop_front();
        check($sformatf("v%0d stall_en", idx), {31'd0, sb.stall_en}, {31'd0, e.stall});
        check($sformatf("v%0d issue", idx), {31'd0, sb.issue}, {31'd0, e.issue});
        @(posedge clk); #1;
        check($sformatf("v%0d busy_mask", idx), sb.busy_mask, e.mask);
        check($sformatf("v%0d deadlock", idx), {31'd0, sb.deadlock}, 32'd0);
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        //             v rs rt rd urs urt wrd wbv wbrd st is mask
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 32'h0000_0000));
        vecs.push_back(mk(1, 0, 0, 5, 0, 0, 1, 0, 0,  1, 1, 32'h0000_0020));
        vecs.push_back(mk(1, 5, 0, 1, 1, 0, 0, 0, 0,  0, 0, 32'h0000_0020));
        vecs.push_back(mk(1, 5, 0, 1, 1, 0, 0, 1, 5,  0, 0, 32'h0000_0000));
        vecs.push_back(mk(1, 5, 0, 1, 1, 0, 0, 0, 0,  1, 1, 32'h0000_0000));
        vecs.push_back(mk(1, 0, 0, 6, 0, 0, 1, 0, 0,  1, 1, 32'h0000_0040));
        vecs.push_back(mk(1, 0, 0, 7, 0, 0, 1, 0, 0,  1, 1, 32'h0000_00C0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 6,  1, 0, 32'h0000_0080));
        vecs.push_back(mk(1, 0, 0, 3, 0, 0, 1, 1, 3,  1, 1, 32'h0000_0088));
        vecs.push_back(mk(1, 0, 0, 8, 0, 0, 1, 1, 7,  1, 1, 32'h0000_0108));
        vecs.push_back(mk(1, 0, 0, 8, 0, 0, 1, 0, 0,  0, 0, 32'h0000_0108));
        vecs.push_back(mk(1, 0, 0, 8, 0, 0, 1, 1, 8,  0, 0, 32'h0000_0008));
        vecs.push_back(mk(1, 0, 0, 8, 0, 0, 1, 0, 0,  1, 1, 32'h0000_0108));
        vecs.push_back(mk(0, 8, 0, 0, 1, 0, 0, 0, 0,  1, 0, 32'h0000_0108));
        vecs.push_back(mk(1, 0, 3, 0, 0, 1, 0, 0, 0,  0, 0, 32'h0000_0108));
        vecs.push_back(mk(1, 3, 3, 10, 0, 0, 1, 0, 0, 1, 1, 32'h0000_0508));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0,  1, 1, 32'h0000_0509));
        vecs.push_back(mk(1, 0, 0, 2, 1, 0, 0, 0, 0,  0, 0, 32'h0000_0509));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0,  1, 0, 32'h0000_0508));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 3,  1, 0, 32'h0000_0500));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 8,  1, 0, 32'h0000_0400));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 10, 1, 0, 32'h0000_0000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 11, 1, 0, 32'h0000_0000));

        #2;
        check("reset stall_en", {31'd0, sb.stall_en}, 32'd1);
        check("reset issue", {31'd0, sb.issue}, 32'd0);
        check("reset busy_mask", sb.busy_mask, 32'd0);
        check("reset deadlock", {31'd0, sb.deadlock}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);
        check("queue drained", 32'(expq.size()), 32'd0);

        // Stall counter must restart after a hazard-free cycle.
        drive(1, 0, 0, 9, 0, 0, 1, 0, 0);
        @(posedge clk); #1;
        drive(1, 9, 0, 1, 1, 0, 0, 0, 0);
        repeat (200) @(posedge clk);
        #1;
        check("hold200 stall_en", {31'd0, sb.stall_en}, 32'd0);
        drive(0, 9, 0, 1, 1, 0, 0, 0, 0);
        @(posedge clk); #1;
        drive(1, 9, 0, 1, 1, 0, 0, 0, 0);
        repeat (254) @(posedge clk);
        #1;
        check("254 stalls deadlock", {31'd0, sb.deadlock}, 32'd0);
        @(posedge clk); #1;
        check("255 stalls deadlock", {31'd0, sb.deadlock}, 32'd1);
        @(posedge clk); #1;
        check("256 stalls deadlock", {31'd0, sb.deadlock}, 32'd1);

        // Writeback does not bypass: stall holds in the writeback cycle.
        drive(1, 9, 0, 1, 1, 0, 0, 1, 9);
        #1;
        check("wb cycle stall_en", {31'd0, sb.stall_en}, 32'd0);
        @(posedge clk); #1;
        drive(1, 9, 0, 1, 1, 0, 0, 0, 0);
        #1;
        check("after wb stall_en", {31'd0, sb.stall_en}, 32'd1);
        check("after wb issue", {31'd0, sb.issue}, 32'd1);
        check("sticky deadlock", {31'd0, sb.deadlock}, 32'd1);
        check("after wb mask", sb.busy_mask, 32'd0);

        // Asynchronous reset mid-operation clears state without a clock edge.
        drive(1, 0, 0, 12, 0, 0, 1, 0, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("pre-reset mask", sb.busy_mask, 32'h0000_1000);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset mask", sb.busy_mask, 32'd0);
        check("async reset deadlock", {31'd0, sb.deadlock}, 32'd0);
        check("async reset stall_en", {31'd0, sb.stall_en}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Hazard-detection scoreboard for the Tinker in-order pipeline.
- Sits between the decoder stage and writeback. It tracks which architectural registers have a write in flight.
- It produces the `stall_en` signal that the pc module consumes. That is the producer end of the pc's stall interface.
- Holds fetch/decode whenever the instruction in decode reads or overwrites a register whose pending write has not yet reached the register file.

Parameters:
- NUM_REGS, 32, number of architectural registers tracked.
- REG_AW, 5, register-index width; NUM_REGS <= 2**REG_AW.
- R0_ZERO, 0, when 1, register 0 is never marked busy and never causes a stall.
- TIMEOUT, 255, maximum consecutive stall cycles before `deadlock` is flagged; 8-bit counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- dec_valid  in  1  decode stage holds a valid instruction.
- dec_rs  in  REG_AW  source register A index.
- dec_rt  in  REG_AW  source register B index.
- dec_rd  in  REG_AW  destination register index.
- dec_uses_rs  in  1  instruction reads rs.
- dec_uses_rt  in  1  instruction reads rt.
- dec_writes_rd  in  1  instruction writes rd.
- wb_valid  in  1  writeback commits a register write this cycle.
- wb_rd  in  REG_AW  register index being written back.
- stall_en  out  1  1 = pipeline advances (pc increments); 0 = pc/fetch/decode hold.
- issue  out  1  decode instruction accepted this cycle: dec_valid & stall_en.
- busy_mask  out  NUM_REGS  registered scoreboard, bit i = write to register i pending.
- deadlock  out  1  sticky: stall persisted beyond TIMEOUT cycles.

Behaviour:
- Reset (async, rst_n=0): busy_mask=0, stall counter=0, deadlock=0. Hence stall_en=1 and issue=0 during reset.
- Hazard, combinational from registered busy_mask and current decode inputs:
  - raw_a = dec_uses_rs & busy[dec_rs].
  - raw_b = dec_uses_rt & busy[dec_rt].
  - waw = dec_writes_rd & busy[dec_rd].
  - hazard = dec_valid & (raw_a | raw_b | waw).
  - stall_en = ~hazard.
- No bypass: a writeback in cycle N does not clear a hazard in cycle N. The stall releases in cycle N+1.
- Scoreboard update at posedge:
  - Set bit dec_rd when issue & dec_writes_rd.
  - Clear bit wb_rd when wb_valid.
  - Same index set and cleared in one cycle: set wins. The new writer is younger.
  - Different indices set and cleared: both apply.
- R0_ZERO=1: bit 0 is forced 0 and register 0 is excluded from all hazard terms.
- Index >= NUM_REGS on any input: ignored, no set/clear, no hazard.
- wb_valid to a register that is not busy: no effect, no error.
- Stall counter, 8-bit:
  - Increments each cycle hazard=1 and saturates at 255.
  - Resets to 0 on any cycle hazard=0.
  - deadlock sets when the counter reaches TIMEOUT and hazard=1. It clears only on reset.
- dec_valid=0: stall_en=1, no scoreboard set; counter resets.
- Reset mid-operation: all pending state is discarded immediately. The pipeline owner must also flush in-flight writebacks.
- Latency: hazard-to-stall_en is 0 cycles (combinational); issue-to-busy_mask is 1 cycle.

Test Plan:
- Reset released, dec_valid=0 -> stall_en=1, busy_mask=0, deadlock=0.
- Issue writer rd=5. Next cycle decode uses_rs=1, rs=5 -> stall_en=0 with busy_mask[5]=1. Pulse wb_valid, wb_rd=5 at cycle N -> stall_en still 0 in N, 1 in N+1, issue=1.
- Back-to-back independent writers rd=6, rd=7 -> stall_en=1 throughout; busy_mask=0x000000C0 after both issue. wb_rd=6 -> mask=0x00000080.
- Same cycle: issue writer rd=3 and wb_valid wb_rd=3 (older write) -> busy_mask[3] remains 1 (set wins).
- WAW: busy[8]=1, decode writes_rd=1, rd=8, no sources -> stall_en=0. After wb_rd=8 -> proceeds and busy[8] re-set.
- Hold hazard on rs=9 with no writeback for 256 cycles -> deadlock=1 after 255th stalled cycle. It stays 1 after wb_rd=9 until rst_n low.
